// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared datapath definitions: packer FSM state encoding and
//                default field / word widths for the field packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    // Default packer widths (field width, packed word width)
    localparam int PACK_IN_W  = 8;
    localparam int PACK_OUT_W = 16;

    // Packer state: FILL while fewer than a word of bits is held, FULL once
    // a complete word is waiting to be emitted.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } pack_state_t;

endpackage

`default_nettype wire

// File: rtl/field_packer_field_mask.sv
// ============================================================================
//  Module      : field_mask
//  Description : Combinational field conditioner. Clamps the field length to
//                IN_W, clears bits at or above the length and left-aligns the
//                surviving bits so the oldest bit sits at the field MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_mask #(
    parameter int IN_W  = 8,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic [LEN_W-1:0] i_len,
    output logic [IN_W-1:0]  o_field,
    output logic [LEN_W-1:0] o_len
);

    localparam logic [LEN_W-1:0] c_IN_LEN = LEN_W'(IN_W);

    logic [IN_W-1:0] w_mask;

    // Clamp, mask and left-align; a shift by IN_W yields zero, giving a full mask
    always_comb begin
        o_len   = (i_len > c_IN_LEN) ? c_IN_LEN : i_len;
        w_mask  = ~({IN_W{1'b1}} << o_len);
        o_field = (i_data & w_mask) << (c_IN_LEN - o_len);
    end

endmodule

`default_nettype wire

// File: rtl/field_packer.sv
// ============================================================================
//  Module      : field_packer
//  Description : Streams variable-width fields into an MSB-first accumulator
//                and emits OUT_W-bit packed words over valid/ready. A flush
//                request zero-pads and emits any partial word.
//                Optional build macro FIELD_PACKER_LEN_CHECK_EN adds a sticky
//                len_err output flagging accepted oversize field lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_packer
    import riscv_pkg::*;
#(
    parameter int IN_W  = PACK_IN_W,
    parameter int OUT_W = PACK_OUT_W,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FIELD_PACKER_LEN_CHECK_EN
    ,
    output logic             len_err
`endif
);

    // Accumulator holds one word plus the largest possible overflow field
    localparam int                 c_AW      = OUT_W + IN_W;
    localparam int                 c_CNT_W   = $clog2(c_AW);
    localparam logic [c_CNT_W-1:0] c_OUT_CNT = c_CNT_W'(OUT_W);

    pack_state_t        r_state,      w_state_n;
    logic [c_AW-1:0]    r_acc,        w_acc_n;
    logic [c_CNT_W-1:0] r_cnt,        w_cnt_n;
    logic               r_flush_pend, w_flush_pend_n;
    logic               r_in_ready,   w_in_ready_n;
    logic [OUT_W-1:0]   r_out_data,   w_out_data_n;
    logic               r_out_valid,  w_out_valid_n;

    logic [IN_W-1:0]    w_field_al;
    logic [LEN_W-1:0]   w_len_eff;
    logic [c_AW-1:0]    w_ins;
    logic               w_accept;

    field_mask #(
        .IN_W  (IN_W),
        .LEN_W (LEN_W)
    ) u_field_mask (
        .i_data  (in_data),
        .i_len   (in_len),
        .o_field (w_field_al),
        .o_len   (w_len_eff)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_ins    = {w_field_al, {OUT_W{1'b0}}};

    // Next-state logic: emit in FULL, insert/flush in FILL. Bits below the
    // held count are always zero, so insertion is a plain OR and padding is
    // just a count bump. A word reaches out_valid one edge after the FULL
    // transition, i.e. in the second cycle after the completing handshake.
    always_comb begin
        w_state_n      = r_state;
        w_acc_n        = r_acc;
        w_cnt_n        = r_cnt;
        w_flush_pend_n = r_flush_pend;
        w_out_data_n   = r_out_data;
        w_out_valid_n  = r_out_valid;

        if (r_out_valid && out_ready) begin
            w_out_valid_n = 1'b0;
        end

        if (r_state == ST_FULL) begin
            // Flush while a word waits is deferred to the residue
            if (flush) begin
                w_flush_pend_n = 1'b1;
            end
            if (!r_out_valid || out_ready) begin
                w_out_data_n  = r_acc[c_AW-1 -: OUT_W];
                w_out_valid_n = 1'b1;
                w_acc_n       = r_acc << OUT_W;
                w_cnt_n       = r_cnt - c_OUT_CNT;
                w_state_n     = ST_FILL;
            end
        end else begin
            if (w_accept) begin
                w_acc_n = r_acc | (w_ins >> r_cnt);
                w_cnt_n = r_cnt + c_CNT_W'(w_len_eff);
            end
            // The accepted field (if any) is counted before padding
            if (flush || r_flush_pend) begin
                if (w_cnt_n == '0) begin
                    w_flush_pend_n = 1'b0;
                end else if (w_cnt_n < c_OUT_CNT) begin
                    w_cnt_n        = c_OUT_CNT;
                    w_flush_pend_n = 1'b0;
                end else begin
                    // Field filled a word on its own; pad the residue later
                    w_flush_pend_n = 1'b1;
                end
            end
            w_state_n = (w_cnt_n >= c_OUT_CNT) ? ST_FULL : ST_FILL;
        end

        w_in_ready_n = (w_state_n == ST_FILL) && !w_flush_pend_n;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_acc        <= w_acc_n;
            r_cnt        <= w_cnt_n;
            r_flush_pend <= w_flush_pend_n;
            r_in_ready   <= w_in_ready_n;
            r_out_data   <= w_out_data_n;
            r_out_valid  <= w_out_valid_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

`ifdef FIELD_PACKER_LEN_CHECK_EN
    localparam logic [LEN_W-1:0] c_IN_LEN = LEN_W'(IN_W);

    logic r_len_err;

    // Sticky flag for any accepted oversize length; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_err <= 1'b0;
        end else if (w_accept && (in_len > c_IN_LEN)) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err = r_len_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_field_packer.sv
// ============================================================================
//  Module      : tb_field_packer
//  Description : Self-checking bench for field_packer. A bit-queue reference
//                model predicts packed words into a scoreboard; an output
//                monitor compares every accepted word and checks hold rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_field_packer;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int LEN_W = $clog2(IN_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic [LEN_W-1:0] in_len;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef FIELD_PACKER_LEN_CHECK_EN
    logic             len_err;
`endif

    field_packer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIELD_PACKER_LEN_CHECK_EN
        ,
        .len_err   (len_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit               bits_q[$];
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] cap_q[$];
    bit               held = 1'b0;
    logic [OUT_W-1:0] held_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [OUT_W-1:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return 'x;
    endfunction

    // Reference model: a plain bit stream, cut into words whenever enough bits exist
    function automatic void model_pop();
        logic [OUT_W-1:0] w;
        while (bits_q.size() >= OUT_W) begin
            w = '0;
            for (int i = 0; i < OUT_W; i++) w = {w[OUT_W-2:0], bits_q.pop_front()};
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_push(input logic [IN_W-1:0] d, input int len);
        int l;
        l = (len > IN_W) ? IN_W : len;
        for (int i = l - 1; i >= 0; i--) bits_q.push_back(d[i]);
        model_pop();
    endfunction

    function automatic void model_flush();
        if (bits_q.size() > 0) begin
            while (bits_q.size() < OUT_W) bits_q.push_back(1'b0);
            model_pop();
        end
    endfunction

    // Input side: feed observed handshakes and flushes into the model
    always @(negedge clk) begin
        if (rst) begin
            bits_q.delete();
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) model_push(in_data, int'(in_len));
            if (flush) model_flush();
        end
    end

    // Output side: compare accepted words and check output stability
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid && out_ready) begin
                cap_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                end else begin
                    check("word", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic send(input logic [IN_W-1:0] d, input int len);
        int t;
        in_data  = d;
        in_len   = LEN_W'(len);
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1; in_data = '0; in_len = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        cycles(3);

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        cycles(1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic concatenation and output latency
        out_ready = 1'b1;
        cap_q.delete();
        send(8'd15, 5);
        send(8'd87, 7);
        send(8'h0A, 4);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        cycles(1);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("concat_data", 32'(out_data), 32'h7D7A);
        cycles(1);
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("concat_count", 32'(cap_q.size()), 32'd1);

        // Overflow residue then flush
        cap_q.delete();
        send(8'hAB, 8);
        send(8'hCD, 8);
        send(8'h0E, 4);
        do_flush();
        cycles(4);
        check("resid_count", 32'(cap_q.size()), 32'd2);
        check("resid_w0", 32'(cap_at(0)), 32'hABCD);
        check("resid_w1", 32'(cap_at(1)), 32'hE000);
        check("resid_in_ready", 32'(in_ready), 32'd1);

        // Backpressure
        out_ready = 1'b0;
        cap_q.delete();
        send(8'h12, 8);
        send(8'h34, 8);
        send(8'h56, 8);
        send(8'h78, 8);
        cycles(2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", 32'(out_data), 32'h1234);
        out_ready = 1'b1;
        cycles(4);
        check("bp_count", 32'(cap_q.size()), 32'd2);
        check("bp_w0", 32'(cap_at(0)), 32'h1234);
        check("bp_w1", 32'(cap_at(1)), 32'h5678);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Edge lengths and empty flush
        cap_q.delete();
        do_flush();
        cycles(3);
        check("empty_flush_count", 32'(cap_q.size()), 32'd0);
        check("empty_flush_ready", 32'(in_ready), 32'd1);
        send(8'hFF, 0);
        check("len0_ready", 32'(in_ready), 32'd1);
        send(8'hFF, 3);
        send(8'h00, 8);
        send(8'h00, 5);
        cycles(3);
        check("edge_count", 32'(cap_q.size()), 32'd1);
        check("edge_w0", 32'(cap_at(0)), 32'hE000);

        // Reset mid-operation
        cap_q.delete();
        send(8'hAB, 8);
        rst = 1'b1;
        cycles(1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        send(8'h12, 8);
        send(8'h34, 8);
        cycles(3);
        check("midrst_count", 32'(cap_q.size()), 32'd1);
        check("midrst_w0", 32'(cap_at(0)), 32'h1234);

        // Oversize length is clamped to IN_W
        cap_q.delete();
`ifdef FIELD_PACKER_LEN_CHECK_EN
        check("len_err_clear", 32'(len_err), 32'd0);
`endif
        send(8'hFF, 9);
`ifdef FIELD_PACKER_LEN_CHECK_EN
        check("len_err_set", 32'(len_err), 32'd1);
`endif
        send(8'h00, 8);
        cycles(3);
        check("clamp_count", 32'(cap_q.size()), 32'd1);
        check("clamp_w0", 32'(cap_at(0)), 32'hFF00);
`ifdef FIELD_PACKER_LEN_CHECK_EN
        check("len_err_sticky", 32'(len_err), 32'd1);
        rst = 1'b1;
        cycles(1);
        check("len_err_rst", 32'(len_err), 32'd0);
        rst = 1'b0;
        cycles(1);
`endif

        // Randomized traffic against the model
        cap_q.delete();
        repeat (600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IN_W'($urandom);
            in_len    = LEN_W'($urandom_range(0, 11));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycles(1);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cycles(4);
        do_flush();
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            cycles(1);
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("random_words_seen", 32'(cap_q.size() > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
